// File: rtl/frame_gen_pkg.sv
// Shared types and constants for the RGMII test-frame generator.
// Holds the FSM state set, framing bytes and CRC-32 constants.
package frame_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_HDR,
    ST_PAY,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  localparam int HDR_LEN = 14;
  localparam int PRE_LEN = 7;
  localparam int FCS_LEN = 4;
  localparam int CNT_W   = 16;

endpackage

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step over one byte, reflected form.
// Ports: crc (current register), data (byte, LSB first), crc_next.
module crc32_d8
  import frame_gen_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REFL;
      else                c = c >> 1;
    end
  end

  assign crc_next = c;

endmodule

// File: rtl/rgmii_frame_gen.sv
// Ethernet test-frame source for the 125 MHz RGMII transmit path.
// Ports: clk, reset (async high), enable, [bad_fcs when
// FRAME_GEN_BAD_FCS_EN is defined], tx_data_mux[7:0],
// tx_ctl_mux[1:0], busy, frame_done, frame_count[31:0].
module rgmii_frame_gen
  import frame_gen_pkg::*;
#(
  parameter int          PAYLOAD_LEN = 64,
  parameter int          IFG_BYTES   = 12,
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h020000000001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
`ifdef FRAME_GEN_BAD_FCS_EN
  input  logic        bad_fcs,
`endif
  output logic [7:0]  tx_data_mux,
  output logic [1:0]  tx_ctl_mux,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] frame_count
);

  if (PAYLOAD_LEN < 46 || PAYLOAD_LEN > 1500) begin : g_len_chk
    $error("PAYLOAD_LEN must be in 46..1500");
  end
  if (IFG_BYTES < 12) begin : g_ifg_chk
    $error("IFG_BYTES must be at least 12");
  end

  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_LEN - 1);
  localparam logic [CNT_W-1:0] FCS_DONE = CNT_W'(FCS_LEN - 2);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      crc;
  logic [31:0]      crc_nxt;
  logic [31:0]      seq;
  logic [31:0]      fcs;
  logic [31:0]      fcs_first;
  logic             bad_q;

  assign cnt_inc = cnt + 1'b1;

  // The CRC step runs on the byte currently on the wire, so the
  // last payload byte is folded in on the edge that emits FCS[0].
  crc32_d8 u_crc (
    .crc      (crc),
    .data     (tx_data_mux),
    .crc_next (crc_nxt)
  );

`ifndef FRAME_GEN_BAD_FCS_EN
  assign bad_q = 1'b0;
`endif

  assign fcs       = bad_q ? crc     : ~crc;
  assign fcs_first = bad_q ? crc_nxt : ~crc_nxt;

  function automatic logic [7:0] hdr_byte(input logic [3:0] i);
    logic [111:0] s;
    s = HDR << {i, 3'b000};
    return s[111:104];
  endfunction

  function automatic logic [7:0] pay_byte(
    input logic [CNT_W-1:0] i,
    input logic [31:0]      sq
  );
    logic [7:0] b;
    if (|i[CNT_W-1:2]) begin
      b = i[7:0];
    end else begin
      unique case (i[1:0])
        2'd0: b = sq[31:24];
        2'd1: b = sq[23:16];
        2'd2: b = sq[15:8];
        default: b = sq[7:0];
      endcase
    end
    return b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      crc         <= CRC_INIT;
      seq         <= '0;
      tx_data_mux <= '0;
      tx_ctl_mux  <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
`ifdef FRAME_GEN_BAD_FCS_EN
      bad_q       <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (enable) begin
            state       <= ST_PRE;
            cnt         <= '0;
            seq         <= frame_count;
            tx_data_mux <= PREAMBLE_BYTE;
            tx_ctl_mux  <= 2'b11;
            busy        <= 1'b1;
`ifdef FRAME_GEN_BAD_FCS_EN
            bad_q       <= bad_fcs;
`endif
          end
        end
        ST_PRE: begin
          if (cnt == PRE_LAST) begin
            state       <= ST_SFD;
            cnt         <= '0;
            crc         <= CRC_INIT;
            tx_data_mux <= SFD_BYTE;
          end else begin
            cnt         <= cnt_inc;
            tx_data_mux <= PREAMBLE_BYTE;
          end
        end
        ST_SFD: begin
          state       <= ST_HDR;
          cnt         <= '0;
          tx_data_mux <= hdr_byte(4'd0);
        end
        ST_HDR: begin
          crc <= crc_nxt;
          if (cnt == HDR_LAST) begin
            state       <= ST_PAY;
            cnt         <= '0;
            tx_data_mux <= pay_byte('0, seq);
          end else begin
            cnt         <= cnt_inc;
            tx_data_mux <= hdr_byte(cnt_inc[3:0]);
          end
        end
        ST_PAY: begin
          crc <= crc_nxt;
          if (cnt == PAY_LAST) begin
            state       <= ST_FCS;
            cnt         <= '0;
            tx_data_mux <= fcs_first[7:0];
          end else begin
            cnt         <= cnt_inc;
            tx_data_mux <= pay_byte(cnt_inc, seq);
          end
        end
        ST_FCS: begin
          if (cnt == FCS_LAST) begin
            state       <= ST_IFG;
            cnt         <= '0;
            tx_data_mux <= '0;
            tx_ctl_mux  <= 2'b00;
          end else begin
            cnt         <= cnt_inc;
            tx_data_mux <= fcs[{cnt_inc[1:0], 3'b000} +: 8];
            if (cnt == FCS_DONE) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 1'b1;
            end
          end
        end
        ST_IFG: begin
          if (cnt != IFG_LAST) begin
            cnt <= cnt_inc;
          end else if (enable) begin
            state       <= ST_PRE;
            cnt         <= '0;
            seq         <= frame_count;
            tx_data_mux <= PREAMBLE_BYTE;
            tx_ctl_mux  <= 2'b11;
`ifdef FRAME_GEN_BAD_FCS_EN
            bad_q       <= bad_fcs;
`endif
          end else begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rgmii_frame_gen.md
Name: rgmii_frame_gen

Overview:
Parametrised Ethernet test-frame source for the 125 MHz RGMII transmit path.
- Replaces the fixed ctl-pulse pattern generator.
- Emits complete, valid frames: preamble, SFD, header, payload with sequence number, CRC-32 FCS, inter-frame gap.
- Output is byte-wide plus a 2-bit control pair. It feeds the existing ODDR2 transmit mux directly: low nibble on the rising edge, high nibble on the falling edge.

Parameters:
- PAYLOAD_LEN, 64, payload bytes per frame; legal range 46..1500; elaboration error outside it.
- IFG_BYTES, 12, idle byte-times after each FCS; minimum 12.
- DST_MAC, 48'hFFFFFFFFFFFF, destination address, sent MSB byte first.
- SRC_MAC, 48'h020000000001, source address, sent MSB byte first.
- ETHERTYPE, 16'h88B5, EtherType field, sent MSB byte first.

Ports:
- clk  in  1  125 MHz transmit clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; frames are generated while high
- tx_data_mux  out  8  [3:0] = rising-edge nibble, [7:4] = falling-edge nibble
- tx_ctl_mux  out  2  [0] = TX_EN, [1] = TX_EN xor TX_ER
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse in the cycle the last FCS byte is on tx_data_mux
- frame_count  out  32  frames completed since reset; wraps 0xFFFFFFFF -> 0

Behaviour:
- Reset (async assert; deassert synchronous to clk) forces:
  - state = IDLE
  - tx_data_mux = 0, tx_ctl_mux = 0, busy = 0, frame_done = 0, frame_count = 0
  - byte counter = 0, CRC register = 32'hFFFFFFFF
- All outputs are registered. One byte is produced per clk.
- States and byte counts:
  - IDLE: waits for enable.
  - PRE: 7 bytes of 0x55.
  - SFD: 1 byte of 0xD5.
  - HDR: 14 bytes (DST_MAC, SRC_MAC, ETHERTYPE).
  - PAY: PAYLOAD_LEN bytes.
  - FCS: 4 bytes.
  - IFG: IFG_BYTES cycles.
- Transitions:
  - IDLE -> PRE when enable = 1 at a clk edge. The first 0x55 appears on the outputs on that same edge (latency 1 from enable sample).
  - IFG -> PRE when its last cycle ends and enable = 1; otherwise IFG -> IDLE.
- Enable deassert mid-frame: the current frame and its IFG complete. No truncation.
- tx_ctl_mux:
  - 2'b11 for PRE through the last FCS byte.
  - 2'b00 in IDLE and IFG, with tx_data_mux = 0x00.
- Payload contents:
  - Bytes 0..3 = frame_count value latched at frame start, big-endian.
  - Byte i for i >= 4 = i[7:0].
- CRC:
  - IEEE 802.3 CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF.
  - Covers HDR + PAY bytes only.
  - FCS = ~crc, sent crc[7:0] first.
  - The CRC register is reinitialised during SFD.
- Frame period with enable held high: 8 + 14 + PAYLOAD_LEN + 4 + IFG_BYTES cycles. This is 102 cycles at the defaults.
- frame_count increments in the same cycle frame_done pulses.

Optional Feature:
Macro FRAME_GEN_BAD_FCS_EN.
- Defined:
  - Adds input port bad_fcs (1 bit).
  - bad_fcs is sampled on the IDLE->PRE or IFG->PRE transition edge.
  - If sampled high, that frame's FCS is sent as crc (not inverted), a guaranteed FCS error.
  - frame_count and frame_done behave as for a normal frame.
- Undefined: port absent; FCS is always correct.

Decomposition:
- Package frame_gen_pkg holds:
  - the state enumeration
  - constants PREAMBLE_BYTE = 8'h55, SFD_BYTE = 8'hD5, CRC_INIT = 32'hFFFFFFFF, CRC_POLY_REFL = 32'hEDB88320, CRC_RESIDUE = 32'hDEBB20E3
  - the HDR length 14
- One sub-module, crc32_d8: combinational next-CRC function for one 8-bit input, reflected. It is reusable by a future receive checker.

Test Plan:
- Reset mid-frame: assert reset during PAY -> all outputs 0 within the same cycle (async). After release with enable = 1, the next frame restarts at PRE with payload bytes 0..3 = 00 00 00 00.
- Defaults, enable pulsed high for 1 cycle:
  - exactly 90 bytes with tx_ctl_mux = 2'b11: seven 0x55, one 0xD5, then FF FF FF FF FF FF 02 00 00 00 00 01 88 B5, payload 00 00 00 00 04 05 .. 3F, then 4 FCS bytes
  - then 12 cycles with tx_ctl_mux = 00
  - then IDLE, busy = 0, frame_count = 1
- FCS check: running crc32_d8 over HDR+PAY+FCS gives register 0xDEBB20E3. The FCS also matches a software CRC-32 of the same bytes.
- enable held high for 3 frames: frame starts at cycles 0, 102, 204. frame_done pulses at cycles 89, 191, 293. Payload seq bytes are 0, 1, 2.
- enable dropped at byte 40 of frame 1: frame 1 completes with full FCS and IFG, then IDLE. No second frame.
- FRAME_GEN_BAD_FCS_EN defined, bad_fcs = 1 at start: sent FCS equals the bitwise complement of the good FCS, and the receive residue is not 0xDEBB20E3. The next frame with bad_fcs = 0 is correct.
